// File: rtl/timer_counter_pkg.sv
// Shared codes and field positions for the 8-bit timer.
// Prescale selects, ack bit indices and TCR bit positions.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  localparam int CLR_OVF  = 0;
  localparam int CLR_UDF  = 1;

  localparam int TCR_LOAD = 7;
  localparam int TCR_UD   = 5;
  localparam int TCR_EN   = 4;

  // Number of low prescaler bits that must be all ones for a tick.
  function automatic int cks_bits(input logic [1:0] cks);
    return int'(cks) + 1;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler for the timer counting core.
// Ticks when the selected low bits of psc are all ones.
module timer_prescaler
  import timer_counter_pkg::*;
#(
  parameter int PSC_W = 4
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] mask;

  // Advance while counting, restart the period on load or disable.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psc <= '0;
    end else if (!en || load) begin
      psc <= '0;
    end else begin
      psc <= psc + 1'b1;
    end
  end

  // Select psc[cks:0] and flag the all-ones state.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PSC_W; i++) begin
      if (i < cks_bits(cks)) mask[i] = 1'b1;
    end
    tick = en && !load && ((psc & mask) == mask);
  end

endmodule

// File: rtl/timer_counter.sv
// Counting core of the 8-bit timer: load, up/down count,
// and sticky wrap events acked by the register block.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PSC_W = 4
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic             ud,
  input  logic [1:0]       cks,
  input  logic [CNT_W-1:0] reg_tdr,
  input  logic [1:0]       clr_trig,
  output logic [CNT_W-1:0] tcnt,
  output logic             ovf_trig,
  output logic             udf_trig
);

  logic tick;
  logic ovf_set;
  logic udf_set;

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_psc (
    .pclk   (pclk),
    .preset (preset),
    .en     (en),
    .load   (load),
    .cks    (cks),
    .tick   (tick)
  );

  // A wrap happens on the tick that leaves the end of the range.
  always_comb begin
    ovf_set = tick && !ud && (tcnt == '1);
    udf_set = tick &&  ud && (tcnt == '0);
  end

  // Count value and sticky event flags; a new wrap beats an ack.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tcnt     <= '0;
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
    end else begin
      ovf_trig <= ovf_set ||
                  (ovf_trig && !clr_trig[CLR_OVF]);
      udf_trig <= udf_set ||
                  (udf_trig && !clr_trig[CLR_UDF]);
      if (load) begin
        tcnt <= reg_tdr;
      end else if (tick) begin
        if (ud) tcnt <= tcnt - 1'b1;
        else    tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: reference model compared every
// cycle plus hand-computed directed expectations.
module tb_timer_counter;

  logic       pclk = 1'b0;
  logic       preset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       ud = 1'b0;
  logic [1:0] cks = 2'b00;
  logic [7:0] reg_tdr = 8'h00;
  logic [1:0] clr_trig = 2'b00;
  logic [7:0] tcnt;
  logic       ovf_trig;
  logic       udf_trig;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  timer_counter dut (
    .pclk     (pclk),
    .preset   (preset),
    .en       (en),
    .load     (load),
    .ud       (ud),
    .cks      (cks),
    .reg_tdr  (reg_tdr),
    .clr_trig (clr_trig),
    .tcnt     (tcnt),
    .ovf_trig (ovf_trig),
    .udf_trig (udf_trig)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: m_ph counts pclk since the period
  // restarted; a tick closes every 2^(cks+1) cycles.
  logic [7:0] m_cnt;
  logic       m_ovf;
  logic       m_udf;
  int         m_ph;

  function automatic bit m_tick(input int ph,
                                input logic [1:0] c);
    int per;
    per = 2 << int'(c);
    return (ph % per) == (per - 1);
  endfunction

  wire m_tk = en && !load && m_tick(m_ph, cks);
  wire m_ow = m_tk && !ud && (m_cnt == 8'hFF);
  wire m_uw = m_tk && ud && (m_cnt == 8'h00);

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_cnt <= 8'h00;
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
      m_ph  <= 0;
    end else begin
      m_ovf <= m_ow ? 1'b1 : (clr_trig[0] ? 1'b0 : m_ovf);
      m_udf <= m_uw ? 1'b1 : (clr_trig[1] ? 1'b0 : m_udf);
      if (load) begin
        m_cnt <= reg_tdr;
        m_ph  <= 0;
      end else if (!en) begin
        m_ph <= 0;
      end else begin
        m_ph <= (m_ph + 1) % 16;
        if (m_tick(m_ph, cks))
          m_cnt <= ud ? m_cnt - 8'd1 : m_cnt + 8'd1;
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("model_tcnt", tcnt, m_cnt);
      check("model_ovf", ovf_trig, m_ovf);
      check("model_udf", udf_trig, m_udf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  initial begin
    #2 preset = 1'b1;
    #1;
    check("rst_tcnt", tcnt, 8'h00);
    check("rst_ovf", ovf_trig, 1'b0);
    check("rst_udf", udf_trig, 1'b0);
    @(negedge pclk);
    preset = 1'b0;
    chk_en = 1'b1;

    // T1 up count and overflow, divide by 2
    load = 1'b1; reg_tdr = 8'hFD;
    cyc(1);
    check("t1_load", tcnt, 8'hFD);
    load = 1'b0; en = 1'b1; ud = 1'b0; cks = 2'b00;
    cyc(2); check("t1_fe", tcnt, 8'hFE);
    cyc(2); check("t1_ff", tcnt, 8'hFF);
    check("t1_noovf", ovf_trig, 1'b0);
    cyc(2); check("t1_00", tcnt, 8'h00);
    check("t1_ovf", ovf_trig, 1'b1);

    // T3 ack clears the flag, count unaffected
    clr_trig = 2'b01;
    cyc(1);
    clr_trig = 2'b00;
    check("t3_ovf", ovf_trig, 1'b0);
    check("t3_tcnt", tcnt, 8'h00);

    // T4 wrap and ack on the same edge
    en = 1'b0; load = 1'b1; reg_tdr = 8'hFF;
    cyc(1);
    check("t4_load", tcnt, 8'hFF);
    load = 1'b0; en = 1'b1;
    cyc(1);
    clr_trig = 2'b01;
    cyc(1);
    clr_trig = 2'b00;
    check("t4_ovf", ovf_trig, 1'b1);
    check("t4_tcnt", tcnt, 8'h00);
    clr_trig = 2'b01;
    cyc(1);
    clr_trig = 2'b00;

    // T2 down count and underflow, divide by 4
    en = 1'b0; load = 1'b1; reg_tdr = 8'h02;
    ud = 1'b1; cks = 2'b01;
    cyc(1);
    load = 1'b0; en = 1'b1;
    cyc(3); check("t2_hold", tcnt, 8'h02);
    cyc(1); check("t2_01", tcnt, 8'h01);
    cyc(4); check("t2_00", tcnt, 8'h00);
    check("t2_noudf", udf_trig, 1'b0);
    cyc(4); check("t2_ff", tcnt, 8'hFF);
    check("t2_udf", udf_trig, 1'b1);

    // T5 load while counting, then freeze
    load = 1'b1; reg_tdr = 8'h5A;
    cyc(1);
    check("t5_load", tcnt, 8'h5A);
    load = 1'b0;
    cyc(3); check("t5_psc0", tcnt, 8'h5A);
    cyc(1); check("t5_59", tcnt, 8'h59);
    en = 1'b0;
    cyc(20);
    check("t5_frozen", tcnt, 8'h59);

    // T6 async reset mid-period
    load = 1'b1; reg_tdr = 8'h80;
    cyc(1);
    check("t6_80", tcnt, 8'h80);
    check("t6_udf", udf_trig, 1'b1);
    load = 1'b0; en = 1'b1; cks = 2'b11;
    cyc(3);
    #1 preset = 1'b1;
    #1;
    check("t6_tcnt", tcnt, 8'h00);
    check("t6_udf0", udf_trig, 1'b0);
    check("t6_ovf0", ovf_trig, 1'b0);
    @(negedge pclk);
    preset = 1'b0; en = 1'b0;
    cyc(3);
    check("t6_quiet", {udf_trig, ovf_trig, tcnt}, 10'h000);

    // Sweep every divider and direction across a wrap,
    // with periodic acks and a mid-period ud flip
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        en = 1'b0; load = 1'b1;
        ud = d[0]; cks = c[1:0];
        reg_tdr = d[0] ? 8'h01 : 8'hFE;
        cyc(1);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 40; k++) begin
          clr_trig = (k % 7 == 6) ? 2'b11 : 2'b00;
          if (k == 37) ud = ~ud;
          cyc(1);
        end
        clr_trig = 2'b00;
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
